fp_addsub_pipe: RTL and testbench
=================================

Name: fp_addsub_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 adder/subtractor; successor to the combinational ALU add path.
- One operation per cycle with valid/ready flow control. Exponent/mantissa widths are configurable (half, single, double).
- Adds sticky accumulated exception flags and per-operation rounding mode.
- Sits between the operand issue queue and the result writeback stage.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, fraction field width (hidden bit excluded).
- W, 1+EXP_W+MAN_W, derived total word width; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- op_sub  in  1  0: A+B, 1: A-B (B sign inverted in stage 1).
- round_mode  in  1  1: nearest-even, 0: truncate (toward zero).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  packed result.
- flags  out  5  per-result flags: [0] inexact, [1] underflow, [2] overflow, [3] div_by_0 (always 0), [4] invalid.
- flags_sticky  out  5  OR-accumulation of flags of every result handed off (out_valid&&out_ready).
- clear_flags  in  1  clears flags_sticky.

Behaviour:
- Reset: all stage valid bits 0; out_valid=0, result=0, flags=0, flags_sticky=0. in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight operations.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance. The whole pipeline stalls as one unit.
  - Accept on in_valid&&in_ready.
  - Latency is exactly 3 cycles from accept to out_valid when there is no backpressure. Throughput is 1 per cycle.
  - result/flags hold stable while out_valid && !out_ready.
  - Bubbles propagate as valid=0.
- Stage 1 (unpack/align):
  - Classify zero, subnormal, normal, Inf, NaN. Subnormal inputs are honoured (hidden bit 0, exponent 1).
  - Swap so |A|>=|B|.
  - Right-shift the smaller significand by the exponent difference into a MAN_W+4 bit datapath (hidden, fraction, guard, round, sticky). Shifted-out bits OR into sticky. Differences > MAN_W+3 collapse to sticky only.
- Stage 2 (add/normalise):
  - Effective add or subtract on magnitudes.
  - Carry-out: shift right 1, exponent+1, sticky preserved.
  - Otherwise: leading-zero count, left shift, exponent minus count. The shift is limited so the exponent never goes below 1.
- Stage 3 (round/pack):
  - Nearest-even: increment when G && (R||S||LSB). Truncate: never increment.
  - Rounding carry renormalises (exponent+1).
  - inexact = G||R||S, or any overflow/underflow case.
  - Exponent >= all-ones: result ±Inf, overflow=1, inexact=1 in both round modes.
  - Nonzero result below min normal: flush to zero (same sign), underflow=1, inexact=1.
- Special cases, resolved in stage 1 and carried down the pipe:
  - Any NaN input: canonical qNaN (sign 0, exponent all-ones, fraction MSB 1, rest 0), invalid=1.
  - +Inf + -Inf (effective): qNaN, invalid=1.
  - Inf op finite: that Inf, no flags.
  - Exact zero sum of opposite-sign operands: +0. (-0)+(-0) = -0. (+0)+(-0) = +0.
- flags_sticky update:
  - flags_sticky <= clear_flags ? 0 : flags_sticky | (out_valid&&out_ready ? flags : 0).
  - clear_flags has priority over a same-cycle handoff; that handoff's flags are lost.

Decomposition:
- Package fp_pkg: flag bit index constants (FLG_NX=0, FLG_UF=1, FLG_OF=2, FLG_DZ=3, FLG_NV=4), round-mode constants (RM_TRUNC=0, RM_RNE=1), and a class enum (ZERO, SUB, NORM, INF, NAN).
- One sub-module: fp_lzc (parametrised leading-zero counter, combinational), used in stage 2.

Test Plan:
- Single precision, round_mode=0, out_ready=1: 0x40600000 + 0x40100000 -> 0x40B80000, flags=0, out_valid exactly 3 cycles after accept. With op_sub=1 -> 0x3FA00000.
- Specials: 0x7F800000 + 0xFF800000 -> 0x7FC00000, flags=10000. 0x7FC12345 + 0x3F800000 -> 0x7FC00000, invalid. 0x00000000 + 0x80000000 -> 0x00000000. 0x3F800000 - 0x3F800000 -> 0x00000000.
- Limits: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags=00101. 0x00000001 + 0x00000001 -> 0x00000000, flags=00011. 0x3F800000 + 0x00000001 -> 0x3F800000, inexact in both modes.
- Rounding: 0x3F800000 + 0x33800000 (2^-24), round_mode=1 -> 0x3F800000 (tie to even). 0x3F800001 + 0x33800000, round_mode=1 -> 0x3F800002; round_mode=0 -> 0x3F800001.
- Backpressure: stream 6 back-to-back ops, hold out_ready=0 for 4 cycles mid-stream. Check in_ready drops, no op lost or duplicated, results in order and stable while stalled. Then clear_flags pulsed in the same cycle as an overflow handoff -> flags_sticky=0.
- Half precision (EXP_W=5, MAN_W=10): 0x3C00 + 0x3C00 -> 0x4000. 0x7BFF + 0x7BFF -> 0x7C00, overflow. Assert rst while 2 ops are in flight -> out_valid=0 next cycle, flags_sticky=0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and helpers for the floating-point add/subtract pipeline.
//   - Flag bit positions within the 5-bit exception flag vector.
//   - Rounding-mode encodings carried with each operation.
//   - Operand classification enum and a helper that derives it from field tests.
package fp_pkg;

    localparam int FLG_NX = 0;
    localparam int FLG_UF = 1;
    localparam int FLG_OF = 2;
    localparam int FLG_DZ = 3;
    localparam int FLG_NV = 4;

    localparam logic RM_TRUNC = 1'b0;
    localparam logic RM_RNE   = 1'b1;

    typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_e;

    function automatic fp_class_e fp_classify(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic frac_zero);
        if (exp_zero) return frac_zero ? ZERO : SUB;
        if (exp_ones) return frac_zero ? INF : NAN;
        return NORM;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
//   in_vec : vector to scan (MSB first)
//   cnt    : number of leading zeros; WIDTH when in_vec is all zero
module fp_lzc
    import fp_pkg::*;
#(
    parameter  int WIDTH = 27,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic [CNT_W-1:0] cnt
);

    // Scan upward so the highest set bit is the last assignment and wins.
    always_comb begin
        cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (in_vec[i]) cnt = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor with valid/ready flow control.
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : operand handshake (op_a, op_b, op_sub, round_mode)
//   out_valid/out_ready    : result handshake (result, flags)
//   flags_sticky           : OR of flags of every handed-off result
//   clear_flags            : clears flags_sticky (wins over a same-cycle handoff)
// The whole pipe advances as one unit whenever the output register is free.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_sub,
    input  logic         round_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [4:0]   flags,
    output logic [4:0]   flags_sticky,
    input  logic         clear_flags
);

    localparam int M  = MAN_W + 4;            // hidden, fraction, guard, round, sticky
    localparam int XW = EXP_W + 1;            // exponent with overflow headroom
    localparam int CW = $clog2(M + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [1:0] SP_NONE = 2'd0, SP_NAN = 2'd1, SP_INF = 2'd2;

    function automatic logic round_inc(input logic rm, input logic g, input logic r,
                                       input logic s, input logic lsb);
        return (rm == RM_RNE) && g && (r || s || lsb);
    endfunction

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    fp_class_e        cls_a, cls_b;
    logic             sb_eff, a_ge_b;
    logic [W-2:0]     mag_l, mag_s;
    logic [EXP_W-1:0] e_l, e_s, x_l, x_s, diff;
    logic [MAN_W:0]   sig_l, sig_s;
    logic [2*M-1:0]   wide;
    logic             vld_p1_q, sign_p1_d, sign_p1_q, sub_p1_d, sub_p1_q, rm_p1_d, rm_p1_q;
    logic [1:0]       sp_p1_d, sp_p1_q;
    logic [EXP_W-1:0] exp_p1_d, exp_p1_q;
    logic [M-1:0]     ml_p1_d, ml_p1_q, ms_p1_d, ms_p1_q;

    // Stage 1: classify, order by magnitude, align the smaller significand
    always_comb begin
        sb_eff = op_b[W-1] ^ op_sub;
        cls_a  = fp_classify(op_a[W-2:MAN_W] == '0, op_a[W-2:MAN_W] == EXP_ONES,
                             op_a[MAN_W-1:0] == '0);
        cls_b  = fp_classify(op_b[W-2:MAN_W] == '0, op_b[W-2:MAN_W] == EXP_ONES,
                             op_b[MAN_W-1:0] == '0);
        // Exponent-then-fraction ordering of the packed magnitude is a true magnitude compare.
        a_ge_b = op_a[W-2:0] >= op_b[W-2:0];
        mag_l  = a_ge_b ? op_a[W-2:0] : op_b[W-2:0];
        mag_s  = a_ge_b ? op_b[W-2:0] : op_a[W-2:0];
        e_l    = mag_l[W-2:MAN_W];
        e_s    = mag_s[W-2:MAN_W];
        sig_l  = {e_l != '0, mag_l[MAN_W-1:0]};
        sig_s  = {e_s != '0, mag_s[MAN_W-1:0]};
        x_l    = (e_l == '0) ? EXP_W'(1) : e_l;
        x_s    = (e_s == '0) ? EXP_W'(1) : e_s;
        diff   = x_l - x_s;
        wide   = {sig_s, 3'b000, {M{1'b0}}} >> diff;
        if (32'(diff) > M - 1) begin
            ms_p1_d = {{(M-1){1'b0}}, |sig_s};
        end else begin
            ms_p1_d = {wide[2*M-1:M+1], wide[M] | (|wide[M-1:0])};
        end
        sp_p1_d = SP_NONE;
        if (cls_a == NAN || cls_b == NAN) begin
            sp_p1_d = SP_NAN;
        end else if (cls_a == INF && cls_b == INF && op_a[W-1] != sb_eff) begin
            sp_p1_d = SP_NAN;
        end else if (cls_a == INF || cls_b == INF) begin
            sp_p1_d = SP_INF;
        end
        sign_p1_d = a_ge_b ? op_a[W-1] : sb_eff;
        sub_p1_d  = op_a[W-1] ^ sb_eff;
        exp_p1_d  = x_l;
        ml_p1_d   = {sig_l, 3'b000};
        rm_p1_d   = round_mode;
    end

    logic [M:0]       sum;
    logic [CW-1:0]    lz;
    logic [XW-1:0]    exp_x, lim, shamt;
    logic             vld_p2_q, sign_p2_d, sign_p2_q, zero_p2_d, zero_p2_q, rm_p2_q;
    logic [1:0]       sp_p2_q;
    logic [XW-1:0]    exp_p2_d, exp_p2_q;
    logic [M-1:0]     man_p2_d, man_p2_q;

    // Stage 2: magnitude add/subtract and normalise
    always_comb begin
        sum = sub_p1_q ? ({1'b0, ml_p1_q} - {1'b0, ms_p1_q})
                       : ({1'b0, ml_p1_q} + {1'b0, ms_p1_q});
    end

    fp_lzc #(.WIDTH(M)) u_lzc (
        .in_vec (sum[M-1:0]),
        .cnt    (lz)
    );

    always_comb begin
        exp_x     = {1'b0, exp_p1_q};
        // Never shift the exponent below 1; what remains is a subnormal-range result.
        lim       = exp_x - XW'(1);
        shamt     = (XW'(lz) > lim) ? lim : XW'(lz);
        zero_p2_d = (sum == '0);
        if (sum[M]) begin
            man_p2_d = {sum[M:2], sum[1] | sum[0]};
            exp_p2_d = exp_x + XW'(1);
        end else begin
            man_p2_d = sum[M-1:0] << shamt;
            exp_p2_d = exp_x - shamt;
        end
        // An exact cancellation is +0; like-signed zeros keep their sign.
        sign_p2_d = (zero_p2_d && sub_p1_q) ? 1'b0 : sign_p1_q;
    end

    logic             rnd_inc, nx;
    logic [MAN_W+1:0] rnd;
    logic [MAN_W:0]   sig_r;
    logic [XW-1:0]    exp_r;
    logic [W-1:0]     result_d, result_q;
    logic [4:0]       flags_d, flags_q, flags_sticky_d, flags_sticky_q;
    logic             out_valid_q;

    // Stage 3: round, detect overflow/underflow, pack
    always_comb begin
        nx      = |man_p2_q[2:0];
        rnd_inc = round_inc(rm_p2_q, man_p2_q[2], man_p2_q[1], man_p2_q[0], man_p2_q[3]);
        rnd     = {1'b0, man_p2_q[M-1:3]} + (MAN_W+2)'(rnd_inc);
        if (rnd[MAN_W+1]) begin
            sig_r = rnd[MAN_W+1:1];
            exp_r = exp_p2_q + XW'(1);
        end else begin
            sig_r = rnd[MAN_W:0];
            exp_r = exp_p2_q;
        end
        flags_d = '0;
        if (sp_p2_q == SP_NAN) begin
            result_d        = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            flags_d[FLG_NV] = 1'b1;
        end else if (sp_p2_q == SP_INF) begin
            result_d = {sign_p2_q, EXP_ONES, {MAN_W{1'b0}}};
        end else if (zero_p2_q) begin
            result_d = {sign_p2_q, {(W-1){1'b0}}};
        end else if (exp_r >= {1'b0, EXP_ONES}) begin
            result_d        = {sign_p2_q, EXP_ONES, {MAN_W{1'b0}}};
            flags_d[FLG_OF] = 1'b1;
            flags_d[FLG_NX] = 1'b1;
        end else if (!sig_r[MAN_W]) begin
            result_d        = {sign_p2_q, {(W-1){1'b0}}};
            flags_d[FLG_UF] = 1'b1;
            flags_d[FLG_NX] = 1'b1;
        end else begin
            result_d        = {sign_p2_q, exp_r[EXP_W-1:0], sig_r[MAN_W-1:0]};
            flags_d[FLG_NX] = nx;
        end
        flags_sticky_d = clear_flags ? 5'b0
                       : flags_sticky_q | ((out_valid_q && out_ready) ? flags_q : 5'b0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (advance) begin
            vld_p1_q    <= in_valid;
            vld_p2_q    <= vld_p1_q;
            out_valid_q <= vld_p2_q;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            sp_p1_q   <= sp_p1_d;
            sign_p1_q <= sign_p1_d;
            sub_p1_q  <= sub_p1_d;
            rm_p1_q   <= rm_p1_d;
            exp_p1_q  <= exp_p1_d;
            ml_p1_q   <= ml_p1_d;
            ms_p1_q   <= ms_p1_d;
            sp_p2_q   <= sp_p1_q;
            sign_p2_q <= sign_p2_d;
            zero_p2_q <= zero_p2_d;
            rm_p2_q   <= rm_p1_q;
            exp_p2_q  <= exp_p2_d;
            man_p2_q  <= man_p2_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) flags_sticky_q <= '0;
        else     flags_sticky_q <= flags_sticky_d;
    end

    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign flags        = flags_q;
    assign flags_sticky = flags_sticky_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single-precision and half-precision instances.
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        sp_in_valid, sp_in_ready, sp_op_sub, sp_round_mode;
    logic        sp_out_valid, sp_out_ready, sp_clear_flags;
    logic [31:0] sp_op_a, sp_op_b, sp_result;
    logic [4:0]  sp_flags, sp_flags_sticky;

    logic        hp_in_valid, hp_in_ready, hp_op_sub, hp_round_mode;
    logic        hp_out_valid, hp_out_ready, hp_clear_flags;
    logic [15:0] hp_op_a, hp_op_b, hp_result;
    logic [4:0]  hp_flags, hp_flags_sticky;

    fp_addsub_pipe u_sp (
        .clk(clk), .rst(rst), .in_valid(sp_in_valid), .in_ready(sp_in_ready),
        .op_a(sp_op_a), .op_b(sp_op_b), .op_sub(sp_op_sub), .round_mode(sp_round_mode),
        .out_valid(sp_out_valid), .out_ready(sp_out_ready), .result(sp_result),
        .flags(sp_flags), .flags_sticky(sp_flags_sticky), .clear_flags(sp_clear_flags)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_hp (
        .clk(clk), .rst(rst), .in_valid(hp_in_valid), .in_ready(hp_in_ready),
        .op_a(hp_op_a), .op_b(hp_op_b), .op_sub(hp_op_sub), .round_mode(hp_round_mode),
        .out_valid(hp_out_valid), .out_ready(hp_out_ready), .result(hp_result),
        .flags(hp_flags), .flags_sticky(hp_flags_sticky), .clear_flags(hp_clear_flags)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation with out_ready=1 and check latency, result and flags.
    task automatic run_op(input bit hp, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic rm, input logic [31:0] er,
                          input logic [4:0] ef, input string tag);
        int n;
        if (hp) begin
            hp_in_valid = 1'b1; hp_op_a = a[15:0]; hp_op_b = b[15:0];
            hp_op_sub = sub; hp_round_mode = rm;
        end else begin
            sp_in_valid = 1'b1; sp_op_a = a; sp_op_b = b;
            sp_op_sub = sub; sp_round_mode = rm;
        end
        #1;
        check({tag, ":in_ready"}, 64'(hp ? hp_in_ready : sp_in_ready), 64'(1));
        @(posedge clk); #1;
        sp_in_valid = 1'b0;
        hp_in_valid = 1'b0;
        n = 1;
        while (!(hp ? hp_out_valid : sp_out_valid) && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ":valid"}, 64'(hp ? hp_out_valid : sp_out_valid), 64'(1));
        check({tag, ":latency"}, 64'(n), 64'(3));
        check({tag, ":result"}, 64'(hp ? {16'h0, hp_result} : sp_result), 64'(er));
        check({tag, ":flags"}, 64'(hp ? hp_flags : sp_flags), 64'(ef));
    endtask

    logic [31:0] bp_a [6];
    logic [31:0] bp_e [6];

    initial begin
        int sent, got, stalls, n;
        rst = 1'b1;
        sp_in_valid = 0; sp_op_a = 0; sp_op_b = 0; sp_op_sub = 0; sp_round_mode = 0;
        sp_out_ready = 1; sp_clear_flags = 0;
        hp_in_valid = 0; hp_op_a = 0; hp_op_b = 0; hp_op_sub = 0; hp_round_mode = 0;
        hp_out_ready = 1; hp_clear_flags = 0;
        bp_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        bp_e = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_out_valid", 64'(sp_out_valid), 64'(0));
        check("rst_result", 64'(sp_result), 64'(0));
        check("rst_flags", 64'(sp_flags), 64'(0));
        check("rst_sticky", 64'(sp_flags_sticky), 64'(0));
        check("rst_in_ready", 64'(sp_in_ready), 64'(1));

        run_op(0, 32'h40600000, 32'h40100000, 0, 0, 32'h40B80000, 5'b00000, "add_3p5_2p25");
        run_op(0, 32'h40600000, 32'h40100000, 1, 0, 32'h3FA00000, 5'b00000, "sub_3p5_2p25");
        run_op(0, 32'h7F800000, 32'hFF800000, 0, 0, 32'h7FC00000, 5'b10000, "inf_minus_inf");
        run_op(0, 32'h7FC12345, 32'h3F800000, 0, 0, 32'h7FC00000, 5'b10000, "nan_in");
        run_op(0, 32'h7F800000, 32'h3F800000, 0, 1, 32'h7F800000, 5'b00000, "inf_plus_1");
        run_op(0, 32'h00000000, 32'h80000000, 0, 0, 32'h00000000, 5'b00000, "pz_plus_nz");
        run_op(0, 32'h80000000, 32'h80000000, 0, 0, 32'h80000000, 5'b00000, "nz_plus_nz");
        run_op(0, 32'h3F800000, 32'h3F800000, 1, 1, 32'h00000000, 5'b00000, "one_minus_one");
        run_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 0, 32'h7F800000, 5'b00101, "ovf_trunc");
        run_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 1, 32'h7F800000, 5'b00101, "ovf_rne");
        run_op(0, 32'h00000001, 32'h00000001, 0, 0, 32'h00000000, 5'b00011, "sub_flush");
        run_op(0, 32'h00400000, 32'h00400000, 0, 1, 32'h00800000, 5'b00000, "sub_to_min_norm");
        run_op(0, 32'h3F800000, 32'h00000001, 0, 0, 32'h3F800000, 5'b00001, "tiny_trunc");
        run_op(0, 32'h3F800000, 32'h00000001, 0, 1, 32'h3F800000, 5'b00001, "tiny_rne");
        run_op(0, 32'h3F800000, 32'h33800000, 0, 1, 32'h3F800000, 5'b00001, "tie_even");
        run_op(0, 32'h3F800001, 32'h33800000, 0, 1, 32'h3F800002, 5'b00001, "tie_odd_rne");
        run_op(0, 32'h3F800001, 32'h33800000, 0, 0, 32'h3F800001, 5'b00001, "tie_odd_trunc");
        @(posedge clk); #1;
        check("sticky_accum", 64'(sp_flags_sticky), 64'(5'b10111));
        sp_clear_flags = 1'b1;
        @(posedge clk); #1;
        sp_clear_flags = 1'b0;
        check("sticky_cleared", 64'(sp_flags_sticky), 64'(0));

        // Back-to-back stream with a 4-cycle output stall in the middle.
        sent = 0; got = 0; stalls = 0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            sp_in_valid   = (sent < 6);
            sp_op_a       = bp_a[(sent < 6) ? sent : 0];
            sp_op_b       = 32'h3F800000;
            sp_op_sub     = 1'b0;
            sp_round_mode = 1'b1;
            sp_out_ready  = !(cyc >= 4 && cyc < 8);
            #1;
            if (sp_out_valid && !sp_out_ready) begin
                stalls++;
                check("bp_in_ready_low", 64'(sp_in_ready), 64'(0));
            end
            if (sp_out_valid) check($sformatf("bp_result%0d", got), 64'(sp_result), 64'(bp_e[got]));
            if (sp_out_valid && sp_out_ready) got++;
            if (sp_in_valid && sp_in_ready) sent++;
            @(posedge clk); #1;
        end
        sp_in_valid  = 1'b0;
        sp_out_ready = 1'b1;
        check("bp_count", 64'(got), 64'(6));
        check("bp_stall_cycles", 64'(stalls), 64'(4));
        for (int i = 0; i < 4; i++) begin
            check("bp_no_dup", 64'(sp_out_valid), 64'(0));
            @(posedge clk); #1;
        end
        check("bp_sticky", 64'(sp_flags_sticky), 64'(0));

        // Clear in the same cycle as an overflow handoff drops that handoff's flags.
        sp_in_valid = 1'b1; sp_op_a = 32'h7F7FFFFF; sp_op_b = 32'h7F7FFFFF; sp_round_mode = 1'b0;
        @(posedge clk); #1;
        sp_in_valid = 1'b0;
        n = 1;
        while (!sp_out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("clr_ovf_flags", 64'(sp_flags), 64'(5'b00101));
        sp_clear_flags = 1'b1;
        @(posedge clk); #1;
        sp_clear_flags = 1'b0;
        check("clr_vs_handoff", 64'(sp_flags_sticky), 64'(0));
        run_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 0, 32'h7F800000, 5'b00101, "ovf_again");
        @(posedge clk); #1;
        check("sticky_ovf", 64'(sp_flags_sticky), 64'(5'b00101));

        // Half precision.
        run_op(1, 32'h3C00, 32'h3C00, 0, 1, 32'h4000, 5'b00000, "hp_one_plus_one");
        run_op(1, 32'h7BFF, 32'h7BFF, 0, 1, 32'h7C00, 5'b00101, "hp_ovf");
        @(posedge clk); #1;
        check("hp_sticky_pre_rst", 64'(hp_flags_sticky), 64'(5'b00101));
        hp_in_valid = 1'b1; hp_op_a = 16'h3C00; hp_op_b = 16'h3C00;
        @(posedge clk); #1;
        hp_op_a = 16'h4000;
        @(posedge clk); #1;
        hp_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("hp_rst_out_valid", 64'(hp_out_valid), 64'(0));
        check("hp_rst_sticky", 64'(hp_flags_sticky), 64'(0));
        check("hp_rst_result", 64'(hp_result), 64'(0));
        check("sp_rst_sticky", 64'(sp_flags_sticky), 64'(0));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("hp_rst_discard", 64'(hp_out_valid), 64'(0));
        end
        check("hp_rst_in_ready", 64'(hp_in_ready), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
